// File: rtl/rail_sort_sequencer.sv
// Purpose : queues decoded digits and, per digit, loads the stepper target, waits for
//           arrival + settling, holds the servo push, then retires the entry.
// Latency : first write into an empty queue -> drv_load two cycles later; MOVE the cycle after.
// Backpr. : digit_ready low while the queue is full; the queue pops only when an entry retires.
// Ports   : clk/reset (async, active-high); digit_valid/digit_in/digit_ready upstream handshake;
//           at_target from the drive; drv_digit/drv_load/drv_en/push_req/push_left to the drive;
//           busy/done/fault/count status; clear_fault leaves the fault state and retries the head.
module rail_sort_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 2000000,
    parameter int PUSH_CYCLES    = 40000000,
    parameter int TIMEOUT_CYCLES = 400000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          digit_valid,
    input  logic [3:0]                    digit_in,
    output logic                          digit_ready,
    input  logic                          at_target,
    output logic [3:0]                    drv_digit,
    output logic                          drv_load,
    output logic                          drv_en,
    output logic                          push_req,
    output logic                          push_left,
    output logic                          busy,
    output logic                          done,
    output logic                          fault,
    input  logic                          clear_fault,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] PUSH_LAST    = 32'(PUSH_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MOVE, S_SETTLE, S_PUSH, S_DONE, S_FAULT
    } state_t;

    state_t state, state_next;

    // ---------------- digit queue ----------------
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          wr_en, pop;

    assign digit_ready = (count_q != CW'(FIFO_DEPTH));
    assign wr_en       = digit_valid && digit_ready;
    assign pop         = (state == S_DONE);
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= digit_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(pop);
        end
    end

    // ---------------- counters ----------------
    // phase_cnt times the current phase (at_target-high run in MOVE/SETTLE, hold time in PUSH);
    // to_cnt spans MOVE and SETTLE together so a drive that never arrives ends in FAULT.
    logic [31:0] phase_cnt, to_cnt;
    logic        settle_hit, push_hit, to_hit;

    assign settle_hit = (phase_cnt == SETTLE_LAST);
    assign push_hit   = (phase_cnt == PUSH_LAST);
    assign to_hit     = (to_cnt == TIMEOUT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (count_q != '0) state_next = S_LOAD;
            S_LOAD:   state_next = S_MOVE;
            // at_target low means motion has started; a run of SETTLE_CYCLES highs means the
            // drive was already on target, so settling proceeds without waiting for motion.
            S_MOVE: begin
                if (to_hit)
                    state_next = S_FAULT;
                else if (!at_target || settle_hit)
                    state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (to_hit)
                    state_next = S_FAULT;
                else if (at_target && settle_hit)
                    state_next = S_PUSH;
            end
            S_PUSH:   if (push_hit) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            S_FAULT:  if (clear_fault) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        drv_load = 1'b0;
        drv_en   = 1'b0;
        push_req = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        case (state)
            S_LOAD:   drv_load = 1'b1;
            S_MOVE,
            S_SETTLE: drv_en = 1'b1;
            // The drive arms its servo only while load is high.
            S_PUSH: begin
                push_req = 1'b1;
                drv_en   = 1'b1;
                drv_load = 1'b1;
            end
            S_DONE:   done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            to_cnt    <= '0;
            drv_digit <= '0;
            push_left <= 1'b0;
            fault     <= 1'b0;
        end else begin
            if (state != state_next)
                phase_cnt <= '0;
            else if ((state == S_PUSH) || ((state == S_MOVE || state == S_SETTLE) && at_target))
                phase_cnt <= (phase_cnt == '1) ? phase_cnt : phase_cnt + 32'd1;
            else
                phase_cnt <= '0;

            if (state == S_LOAD)
                to_cnt <= '0;
            else if ((state == S_MOVE || state == S_SETTLE) && to_cnt != '1)
                to_cnt <= to_cnt + 32'd1;

            // Latch the head as LOAD is entered so it is stable for the whole LOAD cycle.
            if (state == S_IDLE && state_next == S_LOAD) begin
                drv_digit <= mem[rd_ptr];
                push_left <= mem[rd_ptr][0];
            end

            fault <= (state_next == S_FAULT);
        end
    end

endmodule

// File: tb/tb_rail_sort_sequencer.sv
// Purpose : directed bench for rail_sort_sequencer; a done-triggered monitor checks retired
//           digits against a queue of expected entries, the main thread checks cycle timing.
module tb_rail_sort_sequencer;

    localparam int DEPTH = 4;
    localparam int S     = 8;
    localparam int P     = 16;
    localparam int T     = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       at_target = 1'b0;
    logic       clear_fault = 1'b0;
    logic       digit_ready, drv_load, drv_en, push_req, push_left, busy, done, fault;
    logic [3:0] drv_digit;
    logic [2:0] count;

    rail_sort_sequencer #(
        .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S), .PUSH_CYCLES(P), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .digit_valid(digit_valid), .digit_in(digit_in), .digit_ready(digit_ready),
        .at_target(at_target), .drv_digit(drv_digit), .drv_load(drv_load), .drv_en(drv_en),
        .push_req(push_req), .push_left(push_left), .busy(busy), .done(done),
        .fault(fault), .clear_fault(clear_fault), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig;
        logic       left;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one digit for one cycle (caller guarantees digit_ready) and log its expectation.
    task automatic write_digit(input logic [3:0] d, input logic left);
        digit_valid = 1'b1;
        digit_in    = d;
        sb.push_back('{dig: d, left: left});
        tick(1);
        digit_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy && count == 0)
                break;
            tick(1);
        end
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_count"}, count, 0);
    endtask

    // Scoreboard monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got digit %0d, expected no retirement", drv_digit);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("retire_digit", drv_digit, e.dig);
                check("retire_left", push_left, e.left);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [3:0] dig5  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic       left5 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // ---- reset values ----
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_ready", digit_ready, 1);
        check("rst_count", count, 0);
        check("rst_drv_digit", drv_digit, 0);
        check("rst_push_left", push_left, 0);
        check("rst_load", drv_load, 0);
        check("rst_en", drv_en, 0);
        check("rst_push", push_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);

        // ---- single digit 4, drive not yet at target ----
        write_digit(4'd4, 1'b0);
        check("t1_count_p1", count, 1);
        check("t1_load_p1", drv_load, 0);
        tick(1);
        check("t1_load_p2", drv_load, 1);
        check("t1_digit_p2", drv_digit, 4);
        tick(1);
        check("t1_load_p3", drv_load, 0);
        check("t1_en_p3", drv_en, 1);
        tick(3);
        check("t1_en_settle", drv_en, 1);
        check("t1_push_early", push_req, 0);
        at_target = 1'b1;
        tick(S - 1);
        check("t1_push_s_minus1", push_req, 0);
        tick(1);
        check("t1_push_at_s", push_req, 1);
        check("t1_load_in_push", drv_load, 1);
        tick(P - 1);
        check("t1_push_hold_end", push_req, 1);
        tick(1);
        check("t1_done", done, 1);
        check("t1_push_off", push_req, 0);
        tick(1);
        check("t1_done_pulse", done, 0);
        check("t1_count_end", count, 0);
        check("t1_busy_end", busy, 0);
        at_target = 1'b0;

        // ---- five digits into a four-deep queue ----
        at_target = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit_valid = 1'b1;
            digit_in    = dig5[i];
            sb.push_back('{dig: dig5[i], left: left5[i]});
            tick(1);
        end
        digit_in = dig5[4];
        sb.push_back('{dig: dig5[4], left: left5[4]});
        check("t2_ready_full", digit_ready, 0);
        check("t2_count_full", count, 4);
        tick(3);
        check("t2_count_stall", count, 4);
        for (int k = 0; k < 100; k++) begin
            if (digit_ready)
                break;
            tick(1);
        end
        check("t2_ready_after_pop", digit_ready, 1);
        tick(1);
        digit_valid = 1'b0;
        check("t2_count_refill", count, 4);
        wait_idle(400, "t2");

        // ---- digit 0 already on target: MOVE and SETTLE each take S cycles ----
        write_digit(4'd0, 1'b0);
        tick(1);
        check("t3_load", drv_load, 1);
        check("t3_digit", drv_digit, 0);
        tick(1);
        check("t3_move_en", drv_en, 1);
        tick(2 * S - 1);
        check("t3_push_early", push_req, 0);
        tick(1);
        check("t3_push_at_2s", push_req, 1);
        wait_idle(100, "t3");

        // ---- one-cycle at_target glitch during SETTLE ----
        at_target = 1'b0;
        write_digit(4'd7, 1'b1);
        tick(3);
        at_target = 1'b1;
        tick(4);
        at_target = 1'b0;
        tick(1);
        at_target = 1'b1;
        tick(3);
        check("t4_push_unglitched_slot", push_req, 0);
        tick(4);
        check("t4_push_s_minus1", push_req, 0);
        tick(1);
        check("t4_push_delayed", push_req, 1);
        wait_idle(100, "t4");

        // ---- timeout, write during fault, clear and retry ----
        at_target = 1'b0;
        write_digit(4'd9, 1'b1);
        tick(1);
        check("t5_load", drv_load, 1);
        check("t5_digit", drv_digit, 9);
        tick(1);
        tick(T - 1);
        check("t5_fault_early", fault, 0);
        check("t5_en_before", drv_en, 1);
        tick(1);
        check("t5_fault", fault, 1);
        check("t5_en_fault", drv_en, 0);
        check("t5_count_kept", count, 1);
        check("t5_busy_fault", busy, 1);
        write_digit(4'd2, 1'b0);
        check("t5_write_in_fault", count, 2);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("t5_fault_cleared", fault, 0);
        check("t5_idle", busy, 0);
        tick(1);
        check("t5_reload", drv_load, 1);
        check("t5_redigit", drv_digit, 9);
        at_target = 1'b1;
        wait_idle(300, "t5");

        // ---- reset during PUSH ----
        write_digit(4'd3, 1'b1);
        write_digit(4'd6, 1'b0);
        for (int k = 0; k < 100; k++) begin
            if (push_req)
                break;
            tick(1);
        end
        check("t6_in_push", push_req, 1);
        tick(3);
        reset = 1'b1;
        #1;
        check("t6_push_rst", push_req, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_count_rst", count, 0);
        check("t6_ready_rst", digit_ready, 1);
        check("t6_en_rst", drv_en, 0);
        sb.delete();
        tick(2);
        reset = 1'b0;
        at_target = 1'b0;
        tick(3);
        check("t6_busy_after", busy, 0);
        check("t6_count_after", count, 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
